// File: rtl/mux4_arbiter.sv
// Round-robin arbiter for a shared 4:1 word mux. Grants one requester at a time,
// drives the select and presents the selected word over a valid/ready handshake.
module mux4_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       REQ,
  input  logic [3:0]       LOCK,
  input  logic [WIDTH-1:0] DIN0,
  input  logic [WIDTH-1:0] DIN1,
  input  logic [WIDTH-1:0] DIN2,
  input  logic [WIDTH-1:0] DIN3,
  input  logic             READY,
  output logic [3:0]       GNT,
  output logic [1:0]       SEL,
  output logic             VALID,
  output logic [WIDTH-1:0] DOUT
);

  localparam int BW = $clog2(MAX_BEATS + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    sel_q;
  logic [3:0]    gnt_q;
  logic          vld_q;
  logic [BW-1:0] beats_q;

  logic [1:0]    rel_ptr;
  logic [2:0]    idle_pick;
  logic [2:0]    rel_pick;
  logic          burst_more;

  // Returns {found, index} of the first set request starting at ptr.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign rel_ptr    = sel_q + 2'd1;
  assign idle_pick  = rr_pick(REQ, ptr_q);
  assign rel_pick   = rr_pick(REQ, rel_ptr);
  assign burst_more = LOCK[sel_q] && REQ[sel_q] && ((int'(beats_q) + 1) < MAX_BEATS);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      vld_q   <= 1'b0;
      beats_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (idle_pick[2]) begin
            state_q <= GRANT;
            sel_q   <= idle_pick[1:0];
            gnt_q   <= 4'b0001 << idle_pick[1:0];
            vld_q   <= 1'b1;
            beats_q <= '0;
          end
        end
        GRANT: begin
          if (READY && burst_more) begin
            beats_q <= beats_q + 1'b1;
          end else if (READY || !REQ[sel_q]) begin
            // Release: the old owner rotates to lowest priority; hand off with no bubble.
            ptr_q   <= rel_ptr;
            beats_q <= '0;
            if (rel_pick[2]) begin
              sel_q <= rel_pick[1:0];
              gnt_q <= 4'b0001 << rel_pick[1:0];
            end else begin
              state_q <= IDLE;
              sel_q   <= 2'd0;
              gnt_q   <= 4'b0000;
              vld_q   <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign GNT   = gnt_q;
  assign SEL   = sel_q;
  assign VALID = vld_q;

  always_comb begin
    DOUT = '0;
    if (vld_q) begin
      case (sel_q)
        2'd0: DOUT = DIN0;
        2'd1: DOUT = DIN1;
        2'd2: DOUT = DIN2;
        default: DOUT = DIN3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed and randomized bench for mux4_arbiter against a rule-level reference model.
module tb_mux4_arbiter;
  localparam int WIDTH     = 32;
  localparam int MAX_BEATS = 4;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic [3:0]       REQ;
  logic [3:0]       LOCK;
  logic [WIDTH-1:0] din [4];
  logic             READY;
  logic [3:0]       GNT;
  logic [1:0]       SEL;
  logic             VALID;
  logic [WIDTH-1:0] DOUT;

  int checks   = 0;
  int failures = 0;

  int m_owner;
  int m_ptr;
  int m_beats;

  mux4_arbiter #(.WIDTH(WIDTH), .MAX_BEATS(MAX_BEATS)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .LOCK(LOCK),
    .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
    .READY(READY), .GNT(GNT), .SEL(SEL), .VALID(VALID), .DOUT(DOUT)
  );

  always #5 CLK = ~CLK;

  function automatic int rr(int p, logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_beats = 0;
  endtask

  task automatic model_release();
    m_ptr   = (m_owner + 1) % 4;
    m_owner = rr(m_ptr, REQ);
    m_beats = 0;
  endtask

  task automatic model_edge();
    if (m_owner < 0) begin
      m_owner = rr(m_ptr, REQ);
      m_beats = 0;
    end else if (READY) begin
      if (LOCK[m_owner] && REQ[m_owner] && (m_beats + 1 < MAX_BEATS)) m_beats++;
      else model_release();
    end else if (!REQ[m_owner]) begin
      model_release();
    end
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [3:0]       eg;
    logic [WIDTH-1:0] ed;
    eg = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    ed = (m_owner < 0) ? '0 : din[m_owner];
    chk({tag, ".gnt"}, 64'(GNT), 64'(eg));
    chk({tag, ".valid"}, 64'(VALID), 64'(m_owner >= 0));
    chk({tag, ".dout"}, 64'(DOUT), 64'(ed));
    if (m_owner >= 0) chk({tag, ".sel"}, 64'(SEL), 64'(m_owner));
  endtask

  task automatic step(string tag);
    @(posedge CLK);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic check_zero(string tag);
    chk({tag, ".gnt"}, 64'(GNT), 64'h0);
    chk({tag, ".sel"}, 64'(SEL), 64'h0);
    chk({tag, ".valid"}, 64'(VALID), 64'h0);
    chk({tag, ".dout"}, 64'(DOUT), 64'h0);
  endtask

  // Called one time unit after an edge; leaves reset released before the next edge.
  task automatic do_reset(string tag);
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_zero(tag);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  int exp_rr [6] = '{0, 1, 2, 3, 0, 1};
  logic [3:0]       hold_g;
  logic [1:0]       hold_s;
  logic [WIDTH-1:0] hold_d;

  initial begin
    for (int i = 0; i < 4; i++) din[i] = $urandom | 32'h1;
    REQ = 4'b1111; LOCK = 4'b0000; READY = 1'b1; RST_N = 1'b0;
    model_reset();
    #1;
    check_zero("rst_async");
    repeat (2) @(posedge CLK);
    #1;
    check_zero("rst_held");
    RST_N = 1'b1;

    // Round robin from reset
    step("rr0");
    chk("rr_first_gnt", 64'(GNT), 64'h1);
    chk("rr_sel0", 64'(SEL), 64'(exp_rr[0]));
    for (int i = 1; i < 6; i++) begin
      step("rr");
      chk("rr_sel", 64'(SEL), 64'(exp_rr[i]));
      chk("rr_valid", 64'(VALID), 64'h1);
    end

    // Single requester, dropped after the accepted beat
    REQ = 4'b0000;
    step("drain1");
    REQ = 4'b0010; din[1] = 32'hDEADBEEF;
    step("single");
    chk("single_sel", 64'(SEL), 64'h1);
    chk("single_dout", 64'(DOUT), 64'hDEADBEEF);
    REQ = 4'b0000;
    step("single_rel");
    chk("single_idle", 64'(VALID), 64'h0);

    // Burst cap
    do_reset("rst_burst");
    REQ = 4'b0101; LOCK = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      step("burst");
      chk("burst_sel0", 64'(SEL), 64'h0);
    end
    step("burst_end");
    chk("burst_sel2", 64'(SEL), 64'h2);

    // Stall then withdraw
    REQ = 4'b0000; LOCK = 4'b0000;
    step("drain2");
    step("drain3");
    REQ = 4'b0001; READY = 1'b0;
    step("stall_gnt");
    hold_g = GNT; hold_s = SEL; hold_d = DOUT;
    for (int i = 0; i < 5; i++) begin
      step("stall");
      chk("stall_gnt_hold", 64'(GNT), 64'(hold_g));
      chk("stall_sel_hold", 64'(SEL), 64'(hold_s));
      chk("stall_dout_hold", 64'(DOUT), 64'(hold_d));
    end
    REQ = 4'b1000;
    step("withdraw");
    chk("withdraw_sel3", 64'(SEL), 64'h3);

    // Async reset mid-burst with the pointer moved off zero
    REQ = 4'b0000; READY = 1'b1;
    step("drain4");
    REQ = 4'b0001;
    step("pre0");
    REQ = 4'b0000;
    step("pre0_rel");
    REQ = 4'b0100; LOCK = 4'b0100;
    step("lock_b0");
    step("lock_b1");
    #1;
    RST_N = 1'b0;
    model_reset();
    #1;
    check_zero("mid_rst");
    #1;
    REQ = 4'b1111; LOCK = 4'b0000;
    RST_N = 1'b1;
    step("post_rst");
    chk("post_rst_sel", 64'(SEL), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      REQ   = 4'($urandom);
      LOCK  = 4'($urandom);
      READY = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      if ($urandom_range(0, 79) == 0) do_reset("rnd_rst");
      else step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
